intc_ctrl: RTL and testbench
============================

INTC_CTRL -- requirements
Module: intc_ctrl

Interface
REQ-001 Parameter: NSRC, 8, number of interrupt sources; legal range 1..8.
REQ-002 Port: clk  input  1  core clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous active-low reset.
REQ-004 Port: irq_src  input  NSRC  raw asynchronous interrupt lines from peripherals.
REQ-005 Port: irq  output  1  registered interrupt request to core control.
REQ-006 Port: irq_ack  input  1  one-cycle pulse from core control when the interrupt is taken.
REQ-007 Port: spr_we  input  1  register write strobe.
REQ-008 Port: spr_sel  input  3  register select: 0 PEND, 1 MASK, 2 EDGE, 3 CAUSE, 4 EOI; 5-7 reserved.
REQ-009 Port: spr_wdata  input  32  write data.
REQ-010 Port: spr_rdata  output  32  combinational read data for spr_sel.

Function
REQ-011 Each irq_src bit SHALL pass a two-flop synchronizer (s1, s2) plus a delay flop s3.
REQ-012 EDGE[i]=1: pending[i] SHALL set when s2[i] & ~s3[i]; it is held until cleared.
REQ-013 EDGE[i]=0: pending[i] SHALL equal s2[i] (level); W1C on this bit has no effect.
REQ-014 Writing PEND SHALL clear each edge bit i where spr_wdata[i]=1 (write-1-clear).
REQ-015 A set event and a W1C on the same bit in the same cycle: set wins.
REQ-016 active = pending & MASK; priority SHALL be lowest index highest.
REQ-017 FSM states: IDLE, REQ, SERVICE.
REQ-018 IDLE -> REQ when active != 0; irq SHALL be 1 exactly while in REQ (registered output).
REQ-019 REQ -> IDLE if active == 0 before irq_ack (request withdrawn, irq drops next cycle).
REQ-020 REQ -> SERVICE on irq_ack; same edge: CAUSE = {1'b1, 28'b0, id[2:0]} of highest-priority active bit, and that bit's pending cleared if edge-type.
REQ-021 irq_ack with active == 0 in REQ (same cycle as withdrawal): CAUSE = 32'h0000_00FF (spurious), go SERVICE.
REQ-022 SERVICE -> IDLE on any write to EOI; CAUSE[31] cleared on that write.
REQ-023 irq_ack outside REQ and EOI writes outside SERVICE SHALL be ignored.
REQ-024 No nesting: new active sources during SERVICE remain pending and are requested after returning to IDLE.
REQ-025 Source-edge-to-irq latency from IDLE: 4 clk cycles (s1, s2, pending, irq).
REQ-026 Reads: PEND/MASK/EDGE zero-extended to 32 bits, CAUSE full, EOI and reserved read 0; writes to CAUSE and reserved are ignored.
REQ-027 MASK and EDGE SHALL be plain read/write, bits above NSRC-1 ignored on write and read as 0.
REQ-028 Switching EDGE[i] from 1 to 0 SHALL discard the stored edge pending bit.

Reset
REQ-029 On rst low, asynchronously: state IDLE, irq=0, s1/s2/s3=0, pending=0, MASK=0, EDGE=0, CAUSE=0.
REQ-030 Reset asserted in REQ or SERVICE SHALL abandon the transaction with no ack or EOI required.
REQ-031 spr_rdata after reset: 0 for all spr_sel.

Verification
REQ-032 MASK=0x01, EDGE=0x01, rising pulse on irq_src[0] -> irq=1 exactly 4 cycles later; irq_ack -> CAUSE=0x8000_0000, PEND=0x00, irq=0.
REQ-033 MASK=0xFF, level sources 3 and 5 high -> ack -> CAUSE=0x8000_0003; EOI write -> IDLE, irq re-asserts next cycles (both levels still high).
REQ-034 REQ with source 2 only; clear MASK[2] in the cycle of irq_ack -> CAUSE=0x0000_00FF, state SERVICE, irq=0.
REQ-035 Edge source 4 pending, W1C PEND bit 4 in the same cycle a new edge arrives -> PEND[4]=1.
REQ-036 In SERVICE, assert rst low for one cycle -> irq=0, MASK=0, CAUSE=0, PEND=0; subsequent EOI write leaves state IDLE.
REQ-037 Edge source 1 pulse during SERVICE -> PEND[1]=1, irq stays 0 until EOI, then irq=1 one cycle later.

Source files
------------

// File: rtl/intc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intc_ctrl
// Purpose  : Prioritised interrupt controller with up to 8 sources.
//            Sources can be level or edge sensitive. Lower index means higher
//            priority. A request/ack/EOI handshake runs with the core.
// Revision : 1.0 - initial release
// ============================================================================
module intc_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq,
  input  logic            irq_ack,
  input  logic            spr_we,
  input  logic [2:0]      spr_sel,
  input  logic [31:0]     spr_wdata,
  output logic [31:0]     spr_rdata
);

  localparam logic [2:0] SEL_PEND  = 3'd0;
  localparam logic [2:0] SEL_MASK  = 3'd1;
  localparam logic [2:0] SEL_EDGE  = 3'd2;
  localparam logic [2:0] SEL_CAUSE = 3'd3;
  localparam logic [2:0] SEL_EOI   = 3'd4;

  localparam logic [31:0] CAUSE_SPURIOUS = 32'h0000_00FF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NSRC-1:0] s1;
  logic [NSRC-1:0] s2;
  logic [NSRC-1:0] s3;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_nxt;
  logic [NSRC-1:0] mask_reg;
  logic [NSRC-1:0] mask_nxt;
  logic [NSRC-1:0] edge_reg;
  logic [NSRC-1:0] edge_nxt;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] win_onehot;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] edge_hold;
  logic [2:0]      win_id;
  logic            win_hit;
  logic            take;
  logic [31:0]     cause;
  logic [31:0]     cause_nxt;
  logic            wr_pend;
  logic            wr_mask;
  logic            wr_edge;
  logic            wr_eoi;
  logic            wdata_unused;

  assign wr_pend = spr_we && (spr_sel == SEL_PEND);
  assign wr_mask = spr_we && (spr_sel == SEL_MASK);
  assign wr_edge = spr_we && (spr_sel == SEL_EDGE);
  assign wr_eoi  = spr_we && (spr_sel == SEL_EOI);

  // Upper write-data bits only matter when NSRC < 32; nothing stores them.
  assign wdata_unused = &{1'b0, spr_wdata[31:NSRC]};

  assign mask_nxt = wr_mask ? spr_wdata[NSRC-1:0] : mask_reg;
  assign edge_nxt = wr_edge ? spr_wdata[NSRC-1:0] : edge_reg;

  // The mask is taken write-through so that a MASK write in the ack cycle
  // can withdraw the request and produce a spurious cause.
  assign active = pending & mask_nxt;

  // Select the lowest-indexed active source (highest priority).
  always_comb begin
    win_hit    = 1'b0;
    win_id     = 3'd0;
    win_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (active[i] && !win_hit) begin
        win_hit       = 1'b1;
        win_id        = 3'(i);
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Request/service handshake: next state and cause register value.
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_hit) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_nxt = ST_SERVICE;
          take      = win_hit;
          cause_nxt = win_hit ? {1'b1, 28'b0, win_id} : CAUSE_SPURIOUS;
        end else if (!win_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) begin
          state_nxt     = ST_IDLE;
          cause_nxt[31] = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pending update: edge bits latch rises (set beats any clear), level bits
  // track the synchronised input; an edge bit turned off drops its latch.
  always_comb begin
    rise        = edge_reg & s2 & ~s3;
    w1c         = wr_pend ? spr_wdata[NSRC-1:0] : '0;
    ack_clr     = take ? win_onehot : '0;
    edge_hold   = edge_reg & pending & ~w1c & ~ack_clr;
    pending_nxt = (edge_nxt & (edge_hold | rise)) | (~edge_nxt & s2);
  end

  // Source synchroniser chain plus the edge-detect delay stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Configuration registers and pending flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_reg <= '0;
      edge_reg <= '0;
      pending  <= '0;
    end else begin
      mask_reg <= mask_nxt;
      edge_reg <= edge_nxt;
      pending  <= pending_nxt;
    end
  end

  // Handshake state, registered irq and cause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      irq   <= 1'b0;
      cause <= '0;
    end else begin
      state <= state_nxt;
      irq   <= (state_nxt == ST_REQ);
      cause <= cause_nxt;
    end
  end

  // Register read-back; EOI and reserved selects read as zero.
  always_comb begin
    spr_rdata = 32'h0;
    case (spr_sel)
      SEL_PEND:  spr_rdata = 32'(pending);
      SEL_MASK:  spr_rdata = 32'(mask_reg);
      SEL_EDGE:  spr_rdata = 32'(edge_reg);
      SEL_CAUSE: spr_rdata = cause;
      default:   spr_rdata = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_intc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intc_ctrl
// Purpose  : Self-checking bench for intc_ctrl: directed scenarios followed by
//            randomized traffic compared against a cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intc_ctrl;

  localparam int NSRC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_src = '0;
  logic        irq;
  logic        irq_ack = 1'b0;
  logic        spr_we = 1'b0;
  logic [2:0]  spr_sel = '0;
  logic [31:0] spr_wdata = '0;
  logic [31:0] spr_rdata;

  int checks = 0;
  int failures = 0;

  // Reference model state (state code: 0 idle, 1 requesting, 2 in service)
  logic [7:0]  m_s1, m_s2, m_s3, m_pend, m_mask, m_edge;
  logic [31:0] m_cause;
  int          m_st;
  logic        m_irq;

  intc_ctrl #(.NSRC(NSRC)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .spr_we    (spr_we),
    .spr_sel   (spr_sel),
    .spr_wdata (spr_wdata),
    .spr_rdata (spr_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] sel);
    case (sel)
      3'd0:    return {24'b0, m_pend};
      3'd1:    return {24'b0, m_mask};
      3'd2:    return {24'b0, m_edge};
      3'd3:    return m_cause;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_s3 = '0;
    m_pend = '0; m_mask = '0; m_edge = '0;
    m_cause = '0; m_st = 0; m_irq = 1'b0;
  endtask

  // One clock of the reference model, using the inputs present at the edge.
  task automatic model_step();
    logic [7:0] mk, ed, act, np;
    int hp, st_n;
    mk = (spr_we && spr_sel == 3'd1) ? spr_wdata[7:0] : m_mask;
    ed = (spr_we && spr_sel == 3'd2) ? spr_wdata[7:0] : m_edge;
    act = m_pend & mk;
    hp = -1;
    for (int i = 7; i >= 0; i--) if (act[i]) hp = i;
    np = '0;
    for (int i = 0; i < 8; i++) begin
      if (!ed[i]) np[i] = m_s2[i];
      else if (m_edge[i]) begin
        np[i] = m_pend[i];
        if (spr_we && spr_sel == 3'd0 && spr_wdata[i]) np[i] = 1'b0;
        if (m_st == 1 && irq_ack && hp == i) np[i] = 1'b0;
        if (m_s2[i] && !m_s3[i]) np[i] = 1'b1;
      end
    end
    st_n = m_st;
    if (m_st == 0) begin
      if (hp >= 0) st_n = 1;
    end else if (m_st == 1) begin
      if (irq_ack) begin
        st_n = 2;
        m_cause = (hp >= 0) ? (32'h8000_0000 + 32'(hp)) : 32'h0000_00FF;
      end else if (hp < 0) st_n = 0;
    end else begin
      if (spr_we && spr_sel == 3'd4) begin
        st_n = 0;
        m_cause = m_cause & 32'h7FFF_FFFF;
      end
    end
    m_st = st_n;
    m_irq = (st_n == 1);
    m_pend = np; m_mask = mk; m_edge = ed;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq_src;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    chk("irq_vs_model", {31'b0, irq}, {31'b0, m_irq});
    chk("rdata_vs_model", spr_rdata, model_read(spr_sel));
    spr_we = 1'b0;
    irq_ack = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    spr_sel = sel; spr_we = 1'b1; spr_wdata = data;
    tick();
  endtask

  task automatic rd(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    spr_sel = sel;
    #1;
    chk(tag, spr_rdata, exp);
  endtask

  task automatic wait_irq(input string tag, input int bound);
    int n;
    n = 0;
    while (!irq && n < bound) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, irq}, 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    rst = 1'b0;
    // Reset state: irq low and every register select reads zero.
    for (int s = 0; s < 8; s++) begin
      spr_sel = 3'(s);
      #1;
      chk("reset_rdata", spr_rdata, 32'h0);
    end
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single edge source: 4-cycle latency, then ack clears it.
    wr(3'd1, 32'h01);
    wr(3'd2, 32'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    tick();
    chk("edge_lat3_irq", {31'b0, irq}, 32'h0);
    tick();
    chk("edge_lat4_irq", {31'b0, irq}, 32'h1);
    irq_ack = 1'b1;
    tick();
    chk("edge_ack_irq", {31'b0, irq}, 32'h0);
    rd("edge_ack_cause", 3'd3, 32'h8000_0000);
    rd("edge_ack_pend", 3'd0, 32'h0);
    wr(3'd4, 32'h0);
    rd("edge_eoi_cause", 3'd3, 32'h0);

    // Two level sources: priority picks 3, irq returns after EOI.
    do_reset();
    wr(3'd1, 32'hFF);
    irq_src = 8'h28;
    wait_irq("lvl_irq", 8);
    irq_ack = 1'b1;
    tick();
    rd("lvl_cause", 3'd3, 32'h8000_0003);
    wr(3'd4, 32'h0);
    chk("lvl_eoi_irq", {31'b0, irq}, 32'h0);
    tick();
    chk("lvl_reassert_irq", {31'b0, irq}, 32'h1);

    // Mask withdrawn in the ack cycle: spurious cause, stays in service.
    do_reset();
    wr(3'd1, 32'h04);
    irq_src = 8'h04;
    wait_irq("spur_irq", 8);
    spr_we = 1'b1; spr_sel = 3'd1; spr_wdata = 32'h0; irq_ack = 1'b1;
    tick();
    chk("spur_irq_low", {31'b0, irq}, 32'h0);
    rd("spur_cause", 3'd3, 32'h0000_00FF);
    wr(3'd1, 32'h04);
    tick();
    tick();
    chk("spur_service_irq", {31'b0, irq}, 32'h0);
    wr(3'd4, 32'h0);
    tick();
    chk("spur_after_eoi_irq", {31'b0, irq}, 32'h1);

    // Write-1-clear colliding with a fresh edge: the set wins.
    do_reset();
    irq_src = 8'h00;
    wr(3'd2, 32'h10);
    irq_src = 8'h10;
    tick();
    irq_src = 8'h00;
    tick();
    tick();
    rd("w1c_first_pend", 3'd0, 32'h10);
    tick();
    tick();
    irq_src = 8'h10;
    tick();
    irq_src = 8'h00;
    tick();
    wr(3'd0, 32'h10);
    rd("w1c_collide_pend", 3'd0, 32'h10);
    tick();
    wr(3'd0, 32'h10);
    rd("w1c_alone_pend", 3'd0, 32'h0);

    // Reset during service abandons the transaction.
    do_reset();
    wr(3'd1, 32'h01);
    irq_src = 8'h01;
    wait_irq("svc_rst_irq", 8);
    irq_ack = 1'b1;
    tick();
    rd("svc_rst_cause_pre", 3'd3, 32'h8000_0000);
    do_reset();
    rd("svc_rst_mask", 3'd1, 32'h0);
    rd("svc_rst_cause", 3'd3, 32'h0);
    rd("svc_rst_pend", 3'd0, 32'h0);
    wr(3'd4, 32'h0);
    tick();
    chk("svc_rst_eoi_irq", {31'b0, irq}, 32'h0);
    wr(3'd1, 32'h01);
    wait_irq("svc_rst_idle_irq", 8);
    irq_src = 8'h00;

    // Edge arriving during service waits for EOI.
    do_reset();
    wr(3'd2, 32'h02);
    wr(3'd1, 32'h03);
    irq_src = 8'h01;
    wait_irq("nest_irq", 8);
    irq_ack = 1'b1;
    tick();
    rd("nest_cause", 3'd3, 32'h8000_0000);
    irq_src = 8'h03;
    tick();
    irq_src = 8'h01;
    tick();
    tick();
    rd("nest_pend", 3'd0, 32'h03);
    tick();
    tick();
    tick();
    chk("nest_hold_irq", {31'b0, irq}, 32'h0);
    wr(3'd4, 32'h0);
    chk("nest_eoi_irq", {31'b0, irq}, 32'h0);
    tick();
    chk("nest_after_irq", {31'b0, irq}, 32'h1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
      irq_ack   = ($urandom_range(0, 4) == 0);
      spr_we    = ($urandom_range(0, 3) == 0);
      spr_sel   = 3'($urandom_range(0, 7));
      spr_wdata = $urandom;
      tick();
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
